// File: rtl/gcn_layer_sequencer_pkg.sv
// gcn_pkg: shared state encoding, phase constants and defaults for the GCN layer sequencer
package gcn_pkg;
  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    T_ISSUE = 4'd1,
    T_WAIT  = 4'd2,
    C_ISSUE = 4'd3,
    C_WAIT  = 4'd4,
    A_ISSUE = 4'd5,
    A_WAIT  = 4'd6,
    DONE    = 4'd7,
    ERROR   = 4'd8
  } seq_state_t;
  localparam logic [2:0] PH_END = 3'd7;
  localparam int TIMEOUT_DEFAULT = 1024;
  function automatic logic [2:0] phase_of(seq_state_t s);
    return s == ERROR ? PH_END : 3'(s);
  endfunction
endpackage

// File: rtl/gcn_layer_sequencer_if.sv
// gcn_layer_sequencer_if: control handshake between the layer sequencer and its datapath blocks
interface gcn_layer_sequencer_if #(parameter int CW = 3);
  logic start, abort;
  logic trans_go, trans_row_done, comb_go, comb_done, argmax_go, argmax_done;
  logic busy, done, error;
  logic [CW-1:0] row_idx;
  logic [2:0] phase;
  modport master (
    input  start, abort, trans_row_done, comb_done, argmax_done,
    output trans_go, comb_go, argmax_go, busy, done, error, row_idx, phase
  );
  modport slave (
    output start, abort, trans_row_done, comb_done, argmax_done,
    input  trans_go, comb_go, argmax_go, busy, done, error, row_idx, phase
  );
endinterface

// File: rtl/gcn_layer_sequencer_watchdog.sv
// gcn_watchdog: per-phase cycle counter that flags a wait state lasting TIMEOUT_CYCLES-1 cycles
module gcn_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int WDOG_WIDTH = $clog2(TIMEOUT_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [WDOG_WIDTH-1:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= clear ? '0 : enable ? cnt + WDOG_WIDTH'(1) : cnt;
  assign expired = enable && !clear && cnt == WDOG_WIDTH'(TIMEOUT_CYCLES - 2);
endmodule

// File: rtl/gcn_layer_sequencer.sv
// gcn_layer_sequencer: Moore FSM chaining transform rows, combination and argmax with a watchdog
module gcn_layer_sequencer
  import gcn_pkg::*;
#(
  parameter int FEATURE_ROWS = 6,
  parameter int COUNTER_FEATURE_WIDTH = $clog2(FEATURE_ROWS),
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int WDOG_WIDTH = $clog2(TIMEOUT_CYCLES)
) (
  input logic clk,
  input logic reset,
  gcn_layer_sequencer_if.master bus
);
  seq_state_t state, state_n;
  logic [COUNTER_FEATURE_WIDTH-1:0] row_idx, row_n;
  logic in_wait, expired, last_row;
  assign in_wait = state inside {T_WAIT, C_WAIT, A_WAIT};
  assign last_row = row_idx == COUNTER_FEATURE_WIDTH'(FEATURE_ROWS - 1);
  assign bus.row_idx = row_idx;
  gcn_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .WDOG_WIDTH(WDOG_WIDTH)
  ) u_wdog (
    .clk(clk),
    .reset(reset),
    .clear(!in_wait),
    .enable(in_wait),
    .expired(expired)
  );
  always_comb begin
    state_n = state;
    row_n = row_idx;
    if (bus.abort) begin
      state_n = IDLE;
      row_n = '0;
    end else begin
      unique case (state)
        IDLE: begin
          state_n = bus.start ? T_ISSUE : IDLE;
          row_n = bus.start ? '0 : row_idx;
        end
        T_ISSUE: state_n = T_WAIT;
        T_WAIT: begin
          state_n = bus.trans_row_done ? (last_row ? C_ISSUE : T_ISSUE) : expired ? ERROR : T_WAIT;
          row_n = bus.trans_row_done && !last_row ? row_idx + COUNTER_FEATURE_WIDTH'(1) : row_idx;
        end
        C_ISSUE: state_n = C_WAIT;
        C_WAIT: state_n = bus.comb_done ? A_ISSUE : expired ? ERROR : C_WAIT;
        A_ISSUE: state_n = A_WAIT;
        A_WAIT: state_n = bus.argmax_done ? DONE : expired ? ERROR : A_WAIT;
        DONE, ERROR: state_n = bus.start ? state : IDLE;
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      row_idx <= '0;
      bus.trans_go <= 1'b0;
      bus.comb_go <= 1'b0;
      bus.argmax_go <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.error <= 1'b0;
      bus.phase <= '0;
    end else begin
      state <= state_n;
      row_idx <= row_n;
      bus.trans_go <= state_n == T_ISSUE;
      bus.comb_go <= state_n == C_ISSUE;
      bus.argmax_go <= state_n == A_ISSUE;
      bus.busy <= !(state_n inside {IDLE, DONE, ERROR});
      bus.done <= state_n == DONE;
      bus.error <= state_n == ERROR;
      bus.phase <= phase_of(state_n);
    end
endmodule

// File: tb/tb_gcn_layer_sequencer.sv
// tb_gcn_layer_sequencer: randomized latency runs against an event-timeline model plus directed corner cases
module tb_gcn_layer_sequencer;
  localparam int FR = 6;
  localparam int TO = 16;
  localparam int CW = 3;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  gcn_layer_sequencer_if #(.CW(CW)) bus ();
  gcn_layer_sequencer #(
    .FEATURE_ROWS(FR),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic clear_dones();
    bus.trans_row_done = 1'b0;
    bus.comb_done = 1'b0;
    bus.argmax_done = 1'b0;
  endtask
  task automatic run(input int d[8], output int s_c, output int end_c);
    int exp_cyc[8];
    int n_exp, exp_err, t, k, pending, kind;
    bit fin;
    n_exp = 0;
    exp_err = 0;
    t = cyc + 1;
    for (int i = 0; i < 8; i++) begin
      exp_cyc[i] = t;
      n_exp++;
      if (d[i] >= TO) begin
        exp_err = 1;
        t += TO;
        break;
      end
      t += d[i] + 1;
    end
    s_c = cyc;
    end_c = -1;
    k = 0;
    pending = -1;
    kind = 0;
    fin = 1'b0;
    bus.start = 1'b1;
    for (int n = 0; n < 400 && !fin; n++) begin
      step();
      clear_dones();
      chk("busy", bus.busy, cyc < t);
      if (bus.trans_go || bus.comb_go || bus.argmax_go) begin
        kind = bus.argmax_go ? 2 : bus.comb_go ? 1 : 0;
        if (k < n_exp) begin
          chk("go_kind", kind, k < FR ? 0 : k - FR + 1);
          chk("go_cycle", cyc, exp_cyc[k]);
          if (kind == 0) chk("row_idx", bus.row_idx, k);
          pending = cyc + d[k];
        end else chk("extra_go", k, n_exp);
        k++;
      end
      if (cyc == pending) begin
        bus.trans_row_done = kind == 0;
        bus.comb_done = kind == 1;
        bus.argmax_done = kind == 2;
      end
      if (bus.done || bus.error) begin
        fin = 1'b1;
        end_c = cyc;
        chk("end_cycle", cyc, t);
        chk("error", bus.error, exp_err);
        chk("done", bus.done, exp_err == 0);
        chk("go_count", k, n_exp);
        chk("phase_end", bus.phase, 7);
        if (exp_err == 0) chk("row_hold", bus.row_idx, FR - 1);
      end
    end
    if (!fin) chk("run_finished", 0, 1);
    clear_dones();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_no_go", {bus.trans_go, bus.comb_go, bus.argmax_go}, 0);
      chk("hold_phase", bus.phase, 7);
    end
    bus.start = 1'b0;
    step();
    chk("idle_phase", bus.phase, 0);
    chk("idle_flags", {bus.busy, bus.done, bus.error}, 0);
  endtask
  initial begin
    int d[8];
    int s_c, e_c;
    bit resp, found;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    clear_dones();
    step();
    step();
    chk("reset_outs", {bus.trans_go, bus.comb_go, bus.argmax_go, bus.busy, bus.done, bus.error}, 0);
    chk("reset_row", bus.row_idx, 0);
    chk("reset_phase", bus.phase, 0);
    reset = 1'b0;
    step();
    foreach (d[i]) d[i] = 3;
    run(d, s_c, e_c);
    foreach (d[i]) d[i] = 1;
    run(d, s_c, e_c);
    chk("b2b_total", e_c - s_c - 1, 2 * FR + 4);
    foreach (d[i]) d[i] = 2;
    d[FR] = TO + 10;
    run(d, s_c, e_c);
    foreach (d[i]) d[i] = 2;
    d[FR + 1] = TO - 1;
    run(d, s_c, e_c);
    repeat (8) begin
      foreach (d[i]) d[i] = ($urandom_range(0, 15) == 0) ? int'($urandom_range(TO - 2, TO + 1)) : int'($urandom_range(1, 6));
      run(d, s_c, e_c);
    end
    bus.trans_row_done = 1'b1;
    bus.comb_done = 1'b1;
    bus.argmax_done = 1'b1;
    step();
    clear_dones();
    chk("spur_idle_phase", bus.phase, 0);
    chk("spur_idle_go", {bus.trans_go, bus.comb_go, bus.argmax_go, bus.busy}, 0);
    bus.start = 1'b1;
    resp = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      step();
      bus.trans_row_done = resp;
      resp = 1'b0;
      if (bus.trans_go) begin
        if (bus.row_idx == 3) found = 1'b1;
        else resp = 1'b1;
      end
    end
    chk("abort_reach_row3", found, 1);
    step();
    chk("twait_phase", bus.phase, 2);
    bus.comb_done = 1'b1;
    bus.argmax_done = 1'b1;
    step();
    clear_dones();
    chk("spur_twait_phase", bus.phase, 2);
    chk("spur_twait_row", bus.row_idx, 3);
    bus.abort = 1'b1;
    bus.trans_row_done = 1'b1;
    bus.start = 1'b0;
    step();
    bus.abort = 1'b0;
    chk("abort_phase", bus.phase, 0);
    chk("abort_row", bus.row_idx, 0);
    chk("abort_flags", {bus.busy, bus.error, bus.trans_go}, 0);
    step();
    clear_dones();
    chk("late_done_phase", bus.phase, 0);
    chk("late_done_go", {bus.trans_go, bus.comb_go, bus.argmax_go}, 0);
    bus.start = 1'b1;
    resp = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      step();
      bus.trans_row_done = resp;
      resp = 1'b0;
      if (bus.comb_go) found = 1'b1;
      else if (bus.trans_go) resp = 1'b1;
    end
    chk("reach_comb", found, 1);
    step();
    chk("cwait_phase", bus.phase, 4);
    bus.start = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async_outs", {bus.trans_go, bus.comb_go, bus.argmax_go, bus.busy, bus.done, bus.error}, 0);
    chk("async_row", bus.row_idx, 0);
    chk("async_phase", bus.phase, 0);
    step();
    reset = 1'b0;
    step();
    chk("post_reset_phase", bus.phase, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
